i2c_response_queue: RTL and testbench
=====================================

Name: i2c_response_queue

Overview:
Buffers completed I2C transaction results (address, mode, data) from the I2C master stage. Presents them one at a time to the UART packet transmitter stage, which sends each result to the PC as a start/address/operation/data/stop packet. Each record is issued with a single-cycle data_ready pulse. The record is held stable until the transmitter reports tx_complete. Bursts of sensor results are absorbed, and overflow is reported rather than silently lost.

Parameters:
DEPTH, 4, number of queued records; power of 2, minimum 2.
CNT_W, 8, width of the saturating overflow drop counter.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
resp_valid  input  1  one-cycle pulse: a new I2C result is present on resp_*
resp_address  input  8  register address of the completed instruction
resp_mode  input  8  operation byte; [1:0] op (00 = 1-byte read, 01 = 2-byte read, others = no data); [7] = I2C failure flag, passed through unchanged
resp_data  input  16  read data; [7:0] is the first byte sent
tx_complete  input  1  one-cycle pulse from the transmitter: packet fully sent
data_ready  output  1  one-cycle pulse: toPC_* carry a new record
toPC_address  output  8  head record address
toPC_mode  output  8  head record mode
toPC_data  output  16  head record data
queue_empty  output  1  no records stored
queue_full  output  1  DEPTH records stored
overflow  output  1  sticky: at least one record was dropped
drop_count  output  CNT_W  records dropped, saturating at all-ones
clear_overflow  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async): state = IDLE; pointers and count = 0; all outputs 0 except queue_empty = 1. Storage contents are don't-care.
- Storage is a circular buffer of 32-bit records {address, mode, data}. Write and read pointers are log2(DEPTH) bits wide and wrap naturally. Count is log2(DEPTH)+1 bits.
- Push: resp_valid with count < DEPTH writes the record at wr_ptr; wr_ptr++ and count++.
- Push while full:
  - With no pop in the same cycle: the record is discarded, overflow is set, and drop_count increments, saturating.
  - With a pop in the same cycle (IDLE load): the record is accepted; count is unchanged.
- queue_empty and queue_full are combinational from the registered count.
- clear_overflow zeroes overflow and drop_count. If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_count = 1.
- Issue FSM:
  - IDLE: if count > 0, load the head record into the toPC_* registers, rd_ptr++, count-- (pop), then go to ISSUE. Otherwise stay.
  - ISSUE: data_ready = 1 for exactly this cycle; go to BUSY.
  - BUSY: hold toPC_* unchanged. On tx_complete, go to IDLE. tx_complete is ignored in IDLE and ISSUE.
- Latency:
  - Push into an empty queue in IDLE at cycle N gives data_ready high in cycle N+2.
  - After tx_complete at cycle M, the next queued record gives data_ready in cycle M+2. This guarantees the transmitter has returned to its idle state first.
- toPC_* change only on an IDLE load; they are stable from data_ready through tx_complete.
- Records are delivered in strict FIFO order. Mode and data are never modified; the failure bit and op field pass through.
- Reset mid-transaction: all queued records are lost; data_ready stays 0 until a new push arrives after reset is released.

Test Plan:
- Single record: push addr=0x01, mode=0x01, data=0xBEEF -> data_ready pulse 2 cycles later with toPC_* = 01/01/BEEF; held until tx_complete; queue_empty = 1 afterwards.
- Burst: push 4 records (addr 0x10..0x13) on consecutive cycles with DEPTH=4 while the transmitter is stalled -> no drops. Records are issued in order 0x10..0x13, one per tx_complete, each data_ready exactly 2 cycles after the previous tx_complete.
- Overflow: with the first record popped and held in BUSY, fill the queue (queue_full = 1), then push 3 more -> overflow = 1, drop_count = 3, and only the stored records are emitted. clear_overflow -> both return to 0.
- Full + pop same cycle: queue full in IDLE after tx_complete, and a push coincides with the load cycle -> record accepted, count stays 4, no drop, record emitted last.
- Pass-through and stray events: mode = 0x82 (failure, no-data op) -> toPC_mode = 0x82 unaltered. A tx_complete pulse while in IDLE -> no state change and no pop.
- Async reset asserted in BUSY with 2 records queued -> all outputs 0, queue_empty = 1, no data_ready until a new push arrives.

Source files
------------

// File: rtl/i2c_response_queue.sv
// rtl/i2c_response_queue.sv - FIFO of I2C results issued one at a time to the UART packet transmitter
module i2c_response_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             resp_valid,
   input  logic [7:0]       resp_address,
   input  logic [7:0]       resp_mode,
   input  logic [15:0]      resp_data,
   input  logic             tx_complete,
   output logic             data_ready,
   output logic [7:0]       toPC_address,
   output logic [7:0]       toPC_mode,
   output logic [15:0]      toPC_data,
   output logic             queue_empty,
   output logic             queue_full,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_count,
   input  logic             clear_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DROP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;

   logic [1:0]    state;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic pop;
   logic push;
   logic drop;

   // A full queue still accepts a push when the head is being loaded the same cycle.
   assign pop         = (state == IDLE) && (count != '0);
   assign queue_empty = (count == '0);
   assign queue_full  = (count == FULL_CNT);
   assign push        = resp_valid && (!queue_full || pop);
   assign drop        = resp_valid && queue_full && !pop;
   assign data_ready  = (state == ISSUE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {resp_address, resp_mode, resp_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         toPC_address <= '0;
         toPC_mode    <= '0;
         toPC_data    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            {toPC_address, toPC_mode, toPC_data} <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         case (state)
            IDLE:    if (pop) state <= ISSUE;
            ISSUE:   state <= BUSY;
            BUSY:    if (tx_complete) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A drop in the same cycle as a clear restarts the tally at one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_overflow) begin
            drop_count <= DROP_ONE;
         end else if (!(&drop_count)) begin
            drop_count <= drop_count + DROP_ONE;
         end
      end else if (clear_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_i2c_response_queue.sv
// tb/tb_i2c_response_queue.sv - randomized bench for i2c_response_queue against a queue-based model
module tb_i2c_response_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int DROP_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             resp_valid;
   logic [7:0]       resp_address;
   logic [7:0]       resp_mode;
   logic [15:0]      resp_data;
   logic             tx_complete;
   logic             data_ready;
   logic [7:0]       toPC_address;
   logic [7:0]       toPC_mode;
   logic [15:0]      toPC_data;
   logic             queue_empty;
   logic             queue_full;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;
   logic             clear_overflow;

   i2c_response_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .resp_valid     (resp_valid),
      .resp_address   (resp_address),
      .resp_mode      (resp_mode),
      .resp_data      (resp_data),
      .tx_complete    (tx_complete),
      .data_ready     (data_ready),
      .toPC_address   (toPC_address),
      .toPC_mode      (toPC_mode),
      .toPC_data      (toPC_data),
      .queue_empty    (queue_empty),
      .queue_full     (queue_full),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: waiting records, the record handed to the transmitter, and whether
   // it is about to be announced or is out on the wire awaiting tx_complete.
   logic [31:0] mq[$];
   logic [31:0] head;
   bit          announce;
   bit          on_wire;
   bit          ovf;
   int          drops;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      head     = '0;
      announce = 1'b0;
      on_wire  = 1'b0;
      ovf      = 1'b0;
      drops    = 0;
   endtask

   task automatic compare_outputs();
      check("queue_empty", 32'(queue_empty), 32'(mq.size() == 0));
      check("queue_full", 32'(queue_full), 32'(mq.size() == DEPTH));
      check("data_ready", 32'(data_ready), 32'(announce));
      check("toPC_record", {toPC_address, toPC_mode, toPC_data}, head);
      check("overflow", 32'(overflow), 32'(ovf));
      check("drop_count", 32'(drop_count), 32'(drops));
   endtask

   task automatic step(input int push_pct, input int tx_pct, input int clr_pct);
      logic [31:0] rec;
      bit rv, txc, clr, can_load, dropped;
      int n0;
      @(negedge clk);
      compare_outputs();
      rv  = ($urandom_range(99) < push_pct);
      txc = ($urandom_range(99) < tx_pct);
      clr = ($urandom_range(99) < clr_pct);
      rec = $urandom;
      if ($urandom_range(7) == 0) rec[23:16] = 8'h82;
      resp_valid     = rv;
      {resp_address, resp_mode, resp_data} = rec;
      tx_complete    = txc;
      clear_overflow = clr;

      n0       = mq.size();
      can_load = !announce && !on_wire && (n0 > 0);
      dropped  = 1'b0;
      if (on_wire && txc) on_wire = 1'b0;
      if (announce) begin
         announce = 1'b0;
         on_wire  = 1'b1;
      end
      if (can_load) begin
         head     = mq.pop_front();
         announce = 1'b1;
      end
      if (rv) begin
         if (n0 < DEPTH || can_load) mq.push_back(rec);
         else dropped = 1'b1;
      end
      if (dropped) begin
         ovf   = 1'b1;
         drops = clr ? 1 : ((drops == DROP_MAX) ? DROP_MAX : drops + 1);
      end else if (clr) begin
         ovf   = 1'b0;
         drops = 0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      resp_valid     = 1'b0;
      tx_complete    = 1'b0;
      clear_overflow = 1'b0;
      reset          = 1'b1;
      #1;
      model_reset();
      compare_outputs();
      @(negedge clk);
      compare_outputs();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      resp_valid     = 1'b0;
      resp_address   = '0;
      resp_mode      = '0;
      resp_data      = '0;
      tx_complete    = 1'b0;
      clear_overflow = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_outputs();
      reset = 1'b0;

      for (int i = 0; i < 400; i++) step(30, 30, 2);
      for (int i = 0; i < 100; i++) step(60, 100, 0);
      for (int i = 0; i < 320; i++) step(90, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 100);
      for (int i = 0; i < 20; i++) step(80, 0, 0);
      pulse_reset();
      for (int i = 0; i < 10; i++) step(0, 50, 0);
      for (int i = 0; i < 400; i++) step(50, 40, 3);
      pulse_reset();
      for (int i = 0; i < 300; i++) step(40, 25, 5);
      @(negedge clk);
      compare_outputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
